// File: rtl/standoff_round_ctrl_if.sv
// Signal bundle between the standoff round controller and its environment
// (player input, computer opponent, status outputs).
interface standoff_round_ctrl_if;
  logic       start;
  logic       p1_valid;
  logic [1:0] p1_move;
  logic [2:0] comp_choice;
  logic       comp_load;
  logic [1:0] p1_bullet;
  logic [1:0] comp_bullet;
  logic [7:0] round_count;
  logic       round_done;
  logic       game_over;
  logic [1:0] winner;

  // Environment side: drives control and moves, observes status.
  modport master (
    output start, p1_valid, p1_move, comp_choice,
    input  comp_load, p1_bullet, comp_bullet, round_count,
    input  round_done, game_over, winner
  );

  // Controller side.
  modport slave (
    input  start, p1_valid, p1_move, comp_choice,
    output comp_load, p1_bullet, comp_bullet, round_count,
    output round_done, game_over, winner
  );
endinterface

// File: rtl/standoff_round_ctrl.sv
// Round controller for a reload/shoot/block standoff game between a player
// and a computer opponent. One round: take player move, ask the computer to
// latch the bullet counts, wait for its answer, resolve, repeat until a hit
// or the round limit.
module standoff_round_ctrl #(
  parameter int MAX_ROUNDS = 15,
  parameter int COMP_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  standoff_round_ctrl_if.slave  bus
);

  localparam logic [7:0] LP_MAX_ROUNDS = 8'(MAX_ROUNDS);
  localparam logic [3:0] LP_LAT_LAST   = 4'(COMP_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_P1,
    S_LOAD_COMP,
    S_WAIT_COMP,
    S_RESOLVE,
    S_GAME_OVER
  } state_t;

  state_t     r_state;
  logic [1:0] r_p1_move;
  logic [2:0] r_comp_move;
  logic [3:0] r_lat_cnt;
  logic [1:0] r_p1_bullet;
  logic [1:0] r_comp_bullet;
  logic [7:0] r_round_count;
  logic       r_comp_load;
  logic       r_round_done;
  logic       r_game_over;
  logic [1:0] r_winner;

  // Classify each side's move. A shoot with an empty gun is a fizzle: it
  // neither shoots nor blocks, so it leaves that side exposed like a reload.
  logic w_p1_reload, w_p1_shoot, w_p1_fizzle;
  logic w_comp_reload, w_comp_shoot, w_comp_fizzle;
  logic w_p1_hit, w_comp_hit;
  logic [1:0] w_p1_bullet_next, w_comp_bullet_next;
  logic [7:0] w_round_next;
  logic       w_limit_hit;

  assign w_p1_reload   = (r_p1_move == 2'd0);
  assign w_p1_shoot    = (r_p1_move == 2'd1) && (r_p1_bullet != 2'd0);
  assign w_p1_fizzle   = (r_p1_move == 2'd1) && (r_p1_bullet == 2'd0);
  assign w_comp_reload = (r_comp_move == 3'd0);
  assign w_comp_shoot  = (r_comp_move == 3'd1) && (r_comp_bullet != 2'd0);
  assign w_comp_fizzle = (r_comp_move == 3'd1) && (r_comp_bullet == 2'd0);

  // Both valid shots cancel out since neither side is then exposed.
  assign w_p1_hit   = w_p1_shoot   && (w_comp_reload || w_comp_fizzle);
  assign w_comp_hit = w_comp_shoot && (w_p1_reload   || w_p1_fizzle);

  assign w_p1_bullet_next =
      w_p1_reload ? ((r_p1_bullet == 2'd3) ? 2'd3 : r_p1_bullet + 2'd1) :
      w_p1_shoot  ? r_p1_bullet - 2'd1 : r_p1_bullet;
  assign w_comp_bullet_next =
      w_comp_reload ? ((r_comp_bullet == 2'd3) ? 2'd3 : r_comp_bullet + 2'd1) :
      w_comp_shoot  ? r_comp_bullet - 2'd1 : r_comp_bullet;

  assign w_round_next = (r_round_count == 8'hFF) ? 8'hFF : r_round_count + 8'd1;
  assign w_limit_hit  = (w_round_next >= LP_MAX_ROUNDS);

  // Game state machine; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_p1_move     <= 2'd0;
      r_comp_move   <= 3'd0;
      r_lat_cnt     <= 4'd0;
      r_p1_bullet   <= 2'd0;
      r_comp_bullet <= 2'd0;
      r_round_count <= 8'd0;
      r_comp_load   <= 1'b0;
      r_round_done  <= 1'b0;
      r_game_over   <= 1'b0;
      r_winner      <= 2'd0;
    end else begin
      r_comp_load  <= 1'b0;
      r_round_done <= 1'b0;
      case (r_state)
        S_IDLE, S_GAME_OVER: begin
          if (bus.start) begin
            r_state       <= S_WAIT_P1;
            r_p1_bullet   <= 2'd0;
            r_comp_bullet <= 2'd0;
            r_round_count <= 8'd0;
            r_winner      <= 2'd0;
            r_game_over   <= 1'b0;
          end
        end
        S_WAIT_P1: begin
          if (bus.p1_valid) begin
            r_p1_move   <= bus.p1_move;
            r_comp_load <= 1'b1;
            r_state     <= S_LOAD_COMP;
          end
        end
        S_LOAD_COMP: begin
          r_lat_cnt <= 4'd0;
          r_state   <= S_WAIT_COMP;
        end
        S_WAIT_COMP: begin
          if (r_lat_cnt == LP_LAT_LAST) begin
            r_comp_move <= bus.comp_choice;
            r_state     <= S_RESOLVE;
          end else begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
          end
        end
        S_RESOLVE: begin
          r_p1_bullet   <= w_p1_bullet_next;
          r_comp_bullet <= w_comp_bullet_next;
          r_round_count <= w_round_next;
          r_round_done  <= 1'b1;
          if (w_p1_hit) begin
            r_winner    <= 2'd1;
            r_game_over <= 1'b1;
            r_state     <= S_GAME_OVER;
          end else if (w_comp_hit) begin
            r_winner    <= 2'd2;
            r_game_over <= 1'b1;
            r_state     <= S_GAME_OVER;
          end else if (w_limit_hit) begin
            r_winner    <= 2'd3;
            r_game_over <= 1'b1;
            r_state     <= S_GAME_OVER;
          end else begin
            r_state <= S_WAIT_P1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.comp_load   = r_comp_load;
  assign bus.p1_bullet   = r_p1_bullet;
  assign bus.comp_bullet = r_comp_bullet;
  assign bus.round_count = r_round_count;
  assign bus.round_done  = r_round_done;
  assign bus.game_over   = r_game_over;
  assign bus.winner      = r_winner;

endmodule

// File: tb/tb_standoff_round_ctrl.sv
// Scoreboard bench for standoff_round_ctrl: each issued round pushes its
// expected outcome and timing; a negedge monitor pops and compares.
module tb_standoff_round_ctrl;

  localparam int LAT  = 3;
  localparam int MAXR = 5;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  standoff_round_ctrl_if bus_if ();

  standoff_round_ctrl #(.MAX_ROUNDS(MAXR), .COMP_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int pb;
    int cb;
    int rc;
    int go;
    int win;
  } exp_t;

  exp_t q_rd[$];
  int   q_ld[$];

  // Reference game state
  int m_pb, m_cb, m_rc, m_over, m_win;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Move kinds: 0 reload, 1 live shot, 2 block, 3 fizzle
  function automatic int kind(input int mv, input int bullets);
    if (mv == 0) return 0;
    if (mv == 1) return (bullets > 0) ? 1 : 3;
    return 2;
  endfunction

  task automatic model_round(input int pm, input int cm);
    int pk, ck;
    pk = kind(pm, m_pb);
    ck = kind(cm, m_cb);
    if (pk == 0) m_pb = (m_pb < 3) ? m_pb + 1 : 3;
    if (pk == 1) m_pb = m_pb - 1;
    if (ck == 0) m_cb = (m_cb < 3) ? m_cb + 1 : 3;
    if (ck == 1) m_cb = m_cb - 1;
    m_rc = (m_rc < 255) ? m_rc + 1 : 255;
    if (pk == 1 && (ck == 0 || ck == 3)) begin
      m_over = 1; m_win = 1;
    end else if (ck == 1 && (pk == 0 || pk == 3)) begin
      m_over = 1; m_win = 2;
    end else if (m_rc >= MAXR) begin
      m_over = 1; m_win = 3;
    end
  endtask

  task automatic model_clear();
    m_pb = 0; m_cb = 0; m_rc = 0; m_over = 0; m_win = 0;
  endtask

  // Monitor: compare every comp_load and round_done pulse with the queues.
  always @(negedge clk) begin
    if (bus_if.comp_load) begin
      if (q_ld.size() == 0) chk("comp_load_unexpected", 1, 0);
      else chk("comp_load_cycle", cyc, q_ld.pop_front());
    end
    if (bus_if.round_done) begin
      if (q_rd.size() == 0) chk("round_done_unexpected", 1, 0);
      else begin
        exp_t e;
        e = q_rd.pop_front();
        chk("round_done_cycle", cyc, e.cyc);
        chk("p1_bullet", int'(bus_if.p1_bullet), e.pb);
        chk("comp_bullet", int'(bus_if.comp_bullet), e.cb);
        chk("round_count", int'(bus_if.round_count), e.rc);
        chk("game_over", int'(bus_if.game_over), e.go);
        chk("winner", int'(bus_if.winner), e.win);
        $display("round: p1 %0d comp %0d rc %0d over %0d win %0d",
                 e.pb, e.cb, e.rc, e.go, e.win);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_comp_load"}, int'(bus_if.comp_load), 0);
    chk({tag, "_round_done"}, int'(bus_if.round_done), 0);
    chk({tag, "_game_over"}, int'(bus_if.game_over), 0);
    chk({tag, "_winner"}, int'(bus_if.winner), 0);
    chk({tag, "_p1_bullet"}, int'(bus_if.p1_bullet), 0);
    chk({tag, "_comp_bullet"}, int'(bus_if.comp_bullet), 0);
    chk({tag, "_round_count"}, int'(bus_if.round_count), 0);
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  // Called at a negedge with the DUT in IDLE/GAME_OVER; leaves it in WAIT_P1.
  task automatic do_start();
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    model_clear();
    check_idle_outputs("after_start");
  endtask

  // Called at a negedge with the DUT in WAIT_P1; returns at the negedge
  // where round_done is high. Between acceptance and resolution, p1_valid,
  // start and comp_choice carry noise that must be ignored.
  task automatic play(input int pm, input int cm);
    exp_t e;
    bit   seen;
    bus_if.p1_valid    = 1'b1;
    bus_if.p1_move     = 2'(pm);
    bus_if.comp_choice = 3'($urandom);
    q_ld.push_back(cyc + 1);
    model_round(pm, cm);
    e.cyc = cyc + LAT + 3;
    e.pb = m_pb; e.cb = m_cb; e.rc = m_rc; e.go = m_over; e.win = m_win;
    q_rd.push_back(e);
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      bus_if.p1_valid    = 1'($urandom);
      bus_if.start       = 1'($urandom);
      bus_if.p1_move     = 2'($urandom);
      bus_if.comp_choice = (k == LAT) ? 3'(cm) : 3'($urandom);
    end
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus_if.round_done) begin
        seen = 1'b1;
        break;
      end
    end
    bus_if.p1_valid = 1'b0;
    bus_if.start    = 1'b0;
    if (!seen) begin
      n_errors++;
      $display("FAIL round_done_timeout: got none expected pulse (cycle %0d)", cyc);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "round_done never arrived");
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_if.start = 1'b1;
    bus_if.p1_valid = 1'b1;
    bus_if.p1_move = 2'd0;
    bus_if.comp_choice = 3'd0;
    model_clear();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    bus_if.start = 1'b0;
    bus_if.p1_valid = 1'b0;
    @(negedge clk);

    // Reload rounds, saturation, then a block/block round hits the limit.
    do_start();
    play(0, 0);
    play(0, 0);
    play(0, 0);
    play(0, 0);
    play(2, 5);
    chk("draw_game_over", int'(bus_if.game_over), 1);
    chk("draw_winner", int'(bus_if.winner), 3);

    // Player hit on a reloading computer.
    do_start();
    play(0, 2);
    play(1, 0);

    // Mutual shots, then computer fizzle against reload.
    do_start();
    play(0, 0);
    play(1, 1);
    play(0, 1);

    // start in WAIT_P1 must be ignored.
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    chk("start_ignored_round_count", int'(bus_if.round_count), m_rc);
    chk("start_ignored_p1_bullet", int'(bus_if.p1_bullet), m_pb);

    // Abort a round with reset while waiting for the computer.
    bus_if.p1_valid = 1'b1;
    bus_if.p1_move  = 2'd0;
    q_ld.push_back(cyc + 1);
    @(negedge clk);
    bus_if.p1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    repeat (LAT + 4) @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Randomized games.
    for (int g = 0; g < 40; g++) begin
      do_start();
      while (!m_over) play(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      chk("game_end_over", int'(bus_if.game_over), 1);
      chk("game_end_winner", int'(bus_if.winner), m_win);
    end

    repeat (2) @(negedge clk);
    chk("pending_round_done", q_rd.size(), 0);
    chk("pending_comp_load", q_ld.size(), 0);
    finish_run();
  end

endmodule

// File: doc/standoff_round_ctrl.md
STANDOFF_ROUND_CTRL -- requirements
Module: standoff_round_ctrl

Interface
REQ-001 SHALL have parameter MAX_ROUNDS, default 15, round limit before declaring a draw (1..255).
REQ-002 SHALL have parameter COMP_LAT, default 2, cycles from comp_load pulse to sampling comp_choice (1..15).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begins a new game when in IDLE or GAME_OVER.
REQ-006 SHALL have port p1_valid  input  1  player move strobe.
REQ-007 SHALL have port p1_move  input  2  player move: 0 reload, 1 shoot, 2 block, 3 treated as block.
REQ-008 SHALL have port comp_choice  input  3  computer move, same encoding; values 3..7 treated as block.
REQ-009 SHALL have port comp_load  output  1  one-cycle pulse telling the computer to latch bullet counts.
REQ-010 SHALL have port p1_bullet  output  2  player bullet count, 0..3.
REQ-011 SHALL have port comp_bullet  output  2  computer bullet count, 0..3.
REQ-012 SHALL have port round_count  output  8  completed rounds in current game.
REQ-013 SHALL have port round_done  output  1  one-cycle pulse after each resolution.
REQ-014 SHALL have port game_over  output  1  level, high in GAME_OVER.
REQ-015 SHALL have port winner  output  2  0 none, 1 player, 2 computer, 3 draw; valid while game_over.

Function
REQ-016 SHALL implement states IDLE, WAIT_P1, LOAD_COMP, WAIT_COMP, RESOLVE, GAME_OVER.
REQ-017 IDLE/GAME_OVER: start=1 -> WAIT_P1 next cycle; bullets, round_count, winner cleared to 0 on that transition.
REQ-018 WAIT_P1: p1_valid=1 captures p1_move into a register -> LOAD_COMP; p1_valid ignored in all other states.
REQ-019 LOAD_COMP: comp_load=1 for exactly this one cycle, with p1_bullet/comp_bullet stable -> WAIT_COMP.
REQ-020 WAIT_COMP: counts COMP_LAT cycles, samples comp_choice on the last cycle -> RESOLVE.
REQ-021 RESOLVE (one cycle): applies rules REQ-022..026, increments round_count, pulses round_done -> WAIT_P1 or GAME_OVER.
REQ-022 Shoot with 0 bullets is a fizzle: no bullet change, counts as neither shoot nor block.
REQ-023 Reload: bullet count +1, saturating at 3.
REQ-024 Valid shoot: shooter count -1; hits if opponent reloaded or fizzled.
REQ-025 Both valid shoot: both -1, no hit, game continues.
REQ-026 Shoot vs block: shooter -1, no hit.
REQ-027 Hit -> GAME_OVER, winner = shooter (1 player, 2 computer).
REQ-028 No hit and round_count reaches MAX_ROUNDS -> GAME_OVER, winner=3.
REQ-029 round_count SHALL saturate, never wrap; game ends at MAX_ROUNDS before 255.
REQ-030 start SHALL be ignored outside IDLE/GAME_OVER.
REQ-031 Latency p1_valid accepted -> round_done SHALL be COMP_LAT+2 cycles.

Reset
REQ-032 reset=1 at a rising edge SHALL force IDLE with all outputs 0 (comp_load, round_done, game_over, winner, bullets, round_count); takes priority over start and p1_valid.
REQ-033 Reset mid-round (any state) SHALL abort the round with no resolution and no round_done pulse.

Verification
REQ-034 reset, start, p1 reload, comp 0 -> comp_load pulse 1 cycle after accept, round_done at accept+COMP_LAT+2, both bullets 1, round_count 1.
REQ-035 Both reload 3 rounds then a 4th -> both bullets stay 3 (saturation), round_count 4, no game_over.
REQ-036 p1 bullets 1, p1 shoot, comp reload -> game_over=1, winner=1, p1_bullet 0.
REQ-037 Both 1 bullet, both shoot -> both 0, no hit; comp shoot with 0 bullets vs p1 reload -> fizzle, p1_bullet 1, game continues.
REQ-038 MAX_ROUNDS=3, block/block every round -> game_over after 3rd round_done, winner=3; then start -> all counters 0, WAIT_P1.
REQ-039 reset asserted in WAIT_COMP -> next cycle IDLE, all outputs 0, no round_done; start during WAIT_P1 ignored.
